// File: rtl/seq_pkg.sv
// Shared constants for the RV32I multi-cycle phase sequencer: state codes,
// opcode values and the opcode legality helper.
package seq_pkg;

    localparam int OPCODE_WIDTH = 7;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_FETCH     = 3'd1;
    localparam logic [2:0] ST_DECODE    = 3'd2;
    localparam logic [2:0] ST_EXECUTE   = 3'd3;
    localparam logic [2:0] ST_MEMORY    = 3'd4;
    localparam logic [2:0] ST_WRITEBACK = 3'd5;
    localparam logic [2:0] ST_FAULT     = 3'd7;

    localparam logic [OPCODE_WIDTH-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OPCODE_WIDTH-1:0] OP_AUIPC  = 7'b0010111;
    localparam logic [OPCODE_WIDTH-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPCODE_WIDTH-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OPCODE_WIDTH-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPCODE_WIDTH-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE_WIDTH-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE_WIDTH-1:0] OP_OPIMM  = 7'b0010011;
    localparam logic [OPCODE_WIDTH-1:0] OP_OP     = 7'b0110011;

    function automatic logic is_legal_opcode(input logic [OPCODE_WIDTH-1:0] op);
        logic legal;
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
            OP_LOAD, OP_STORE, OP_OPIMM, OP_OP: legal = 1'b1;
            default:                            legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/seq_wait_counter.sv
// Memory wait counter; timeout fires in the wait cycle whose increment would
// bring the count to MEM_TIMEOUT.
module seq_wait_counter #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int          TO_WIDTH    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic timeout
);

    logic [TO_WIDTH-1:0] cnt_r;

    // Count stalled memory cycles; clear takes priority over increment.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r <= {TO_WIDTH{1'b0}};
        end else if (clear) begin
            cnt_r <= {TO_WIDTH{1'b0}};
        end else if (inc) begin
            cnt_r <= cnt_r + {{(TO_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign timeout = inc && (cnt_r == TO_WIDTH'(MEM_TIMEOUT - 32'd1));

endmodule

// File: rtl/cpu_phase_sequencer.sv
// Multi-cycle control FSM for the RV32I core: datapath enables and memory handshake.
// Optional retired-instruction counter enabled by defining SEQ_INSTRET_EN.
module cpu_phase_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int          TO_WIDTH    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    run,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    mem_ready,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic                    ir_en,
    output logic                    rs_en,
    output logic                    alu_en,
    output logic                    pc_en,
    output logic                    rd_en,
    output logic                    fault,
    output logic [2:0]              phase,
    output logic [63:0]             instret
);

    logic [2:0] state_r;
    logic [2:0] state_nxt_s;
    logic       waiting_s;
    logic       wait_inc_s;
    logic       wait_clr_s;
    logic       timeout_s;
    logic       mem_req_s, mem_we_s, ir_en_s, rs_en_s, alu_en_s, pc_en_s, rd_en_s;

    // Stall tracking is derived from the state register alone to keep timeout loop-free.
    assign waiting_s  = (state_r == ST_FETCH) || (state_r == ST_MEMORY);
    assign wait_inc_s = waiting_s && !mem_ready;
    assign wait_clr_s = ((state_nxt_s == ST_FETCH) || (state_nxt_s == ST_MEMORY))
                        && (state_nxt_s != state_r);

    seq_wait_counter #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TO_WIDTH    (TO_WIDTH)
    ) u_wait_counter (
        .clk     (clk),
        .rst     (rst),
        .clear   (wait_clr_s),
        .inc     (wait_inc_s),
        .timeout (timeout_s)
    );

    // State register; FAULT is left only through reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and output decode; mem_ready wins over a same-cycle timeout.
    always_comb begin
        state_nxt_s = state_r;
        mem_req_s   = 1'b0;
        mem_we_s    = 1'b0;
        ir_en_s     = 1'b0;
        rs_en_s     = 1'b0;
        alu_en_s    = 1'b0;
        pc_en_s     = 1'b0;
        rd_en_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (run) state_nxt_s = ST_FETCH;
                else     state_nxt_s = ST_IDLE;
            end
            ST_FETCH: begin
                mem_req_s = 1'b1;
                if (mem_ready) begin
                    ir_en_s     = 1'b1;
                    state_nxt_s = ST_DECODE;
                end else if (timeout_s) begin
                    state_nxt_s = ST_FAULT;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                rs_en_s = 1'b1;
                if (is_legal_opcode(opcode)) state_nxt_s = ST_EXECUTE;
                else                         state_nxt_s = ST_FAULT;
            end
            ST_EXECUTE: begin
                alu_en_s = 1'b1;
                if ((opcode == OP_LOAD) || (opcode == OP_STORE)) state_nxt_s = ST_MEMORY;
                else                                             state_nxt_s = ST_WRITEBACK;
            end
            ST_MEMORY: begin
                mem_req_s = 1'b1;
                mem_we_s  = (opcode == OP_STORE);
                if (mem_ready) begin
                    state_nxt_s = ST_WRITEBACK;
                end else if (timeout_s) begin
                    state_nxt_s = ST_FAULT;
                end else begin
                    state_nxt_s = ST_MEMORY;
                end
            end
            ST_WRITEBACK: begin
                pc_en_s = 1'b1;
                if ((opcode == OP_STORE) || (opcode == OP_BRANCH)) rd_en_s = 1'b0;
                else                                               rd_en_s = 1'b1;
                if (run) state_nxt_s = ST_FETCH;
                else     state_nxt_s = ST_IDLE;
            end
            ST_FAULT: begin
                state_nxt_s = ST_FAULT;
            end
            default: begin
                state_nxt_s = ST_FAULT;
            end
        endcase
    end

    assign mem_req = mem_req_s;
    assign mem_we  = mem_we_s;
    assign ir_en   = ir_en_s;
    assign rs_en   = rs_en_s;
    assign alu_en  = alu_en_s;
    assign pc_en   = pc_en_s;
    assign rd_en   = rd_en_s;
    assign fault   = (state_r == ST_FAULT);
    assign phase   = state_r;

`ifdef SEQ_INSTRET_EN
    logic [63:0] instret_r;

    // One retirement per WRITEBACK cycle, natural 64-bit wrap.
    always_ff @(posedge clk) begin
        if (!rst) begin
            instret_r <= 64'd0;
        end else if (state_r == ST_WRITEBACK) begin
            instret_r <= instret_r + 64'd1;
        end else begin
            instret_r <= instret_r;
        end
    end

    assign instret = instret_r;
`else
    assign instret = 64'd0;
`endif

endmodule
